// File: rtl/boc_acq_pkg.sv
// Shared state encodings, nominal NCO words and the centre-out Doppler bin order
// for the B1 pilot acquisition controller.
package boc_acq_pkg;

    typedef logic [3:0] acq_state_t;

    localparam acq_state_t ST_IDLE    = 4'd0;
    localparam acq_state_t ST_START   = 4'd1;
    localparam acq_state_t ST_DWELL   = 4'd2;
    localparam acq_state_t ST_EVAL    = 4'd3;
    localparam acq_state_t ST_BIN_END = 4'd4;
    localparam acq_state_t ST_DETECT  = 4'd5;
    localparam acq_state_t ST_ALIGN   = 4'd6;
    localparam acq_state_t ST_DONE    = 4'd7;
    localparam acq_state_t ST_FAIL    = 4'd8;

    localparam logic [31:0] CAR_FCW_NOM_DEF = 32'd1342177280;
    localparam logic [31:0] PRN_FCW_NOM_DEF = 32'd274609472;
    localparam logic [31:0] DOPP_STEP_DEF   = 32'd214748;

    // Visit index -> signed bin: 0, +1, -1, +2, -2, ...
    function automatic logic signed [4:0] bin_of_idx(input logic [4:0] idx);
        logic [4:0] half;
        half = (idx + 5'd1) >> 1;
        return idx[0] ? $signed(half) : -$signed(half);
    endfunction

endpackage

// File: rtl/acq_peak_tracker.sv
// N-lane maximum search for one dwell plus running peak, second peak and peak phase.
// Ties between lanes keep the lower lane; ties against the held peak keep the held peak.
module acq_peak_tracker
    import boc_acq_pkg::*;
#(
    parameter int N_PARAL    = 4,
    parameter int CORR_WIDTH = 32,
    parameter int PHS_WIDTH  = 14
) (
    input  logic                          rx_clk,
    input  logic                          rx_rst,
    input  logic                          clear,
    input  logic                          update,
    input  logic [PHS_WIDTH-1:0]          base,
    input  logic [N_PARAL*CORR_WIDTH-1:0] acc,
    output logic [CORR_WIDTH-1:0]         peak,
    output logic [CORR_WIDTH-1:0]         peak2,
    output logic [PHS_WIDTH-1:0]          peak_phs
);

    logic [CORR_WIDTH-1:0] best;
    logic [PHS_WIDTH-1:0]  best_k;

    always_comb begin
        best   = acc[0 +: CORR_WIDTH];
        best_k = '0;
        for (int k = 1; k < N_PARAL; k++) begin
            if (acc[k*CORR_WIDTH +: CORR_WIDTH] > best) begin
                best   = acc[k*CORR_WIDTH +: CORR_WIDTH];
                best_k = PHS_WIDTH'(k);
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst || clear) begin
            peak     <= '0;
            peak2    <= '0;
            peak_phs <= '0;
        end else if (update && (best > peak)) begin
            peak2    <= peak;
            peak     <= best;
            peak_phs <= base + best_k;
        end
    end

endmodule

// File: rtl/boc_acq_search.sv
// Code-phase x Doppler acquisition controller: steps correlator dwells, sweeps bins
// centre-out, applies the detection threshold and aligns the tracking PRN generator.
//
//  state   | meaning
//  IDLE    | waiting for rx_start after reset
//  START   | one-cycle lane restart at tx_search_phs with current bin FCWs
//  DWELL   | waiting for the first rx_corr_eop of this dwell
//  EVAL    | advance code-phase base; end of code period closes the bin
//  BIN_END | threshold test; next bin or give up
//  DETECT  | detection results held, FCWs frozen
//  ALIGN   | waiting for tracking PRN phase to equal detected phase
//  DONE    | aligned, tracking released
//  FAIL    | every bin searched without detection
module boc_acq_search
    import boc_acq_pkg::*;
#(
    parameter int                   N_PARAL     = 4,
    parameter int                   CORR_WIDTH  = 32,
    parameter int                   PHS_WIDTH   = 14,
    parameter int                   CODE_LEN    = 8184,
    parameter int                   ACC_WIDTH   = 32,
    parameter int                   N_DOPP      = 15,
    parameter logic [ACC_WIDTH-1:0] DOPP_STEP   = ACC_WIDTH'(DOPP_STEP_DEF),
    parameter int                   CODE_SHIFT  = 4,
    parameter logic [ACC_WIDTH-1:0] CAR_FCW_NOM = ACC_WIDTH'(CAR_FCW_NOM_DEF),
    parameter logic [ACC_WIDTH-1:0] PRN_FCW_NOM = ACC_WIDTH'(PRN_FCW_NOM_DEF)
) (
    input  logic                          rx_clk,
    input  logic                          rx_rst,
    input  logic                          rx_start,
    input  logic [CORR_WIDTH-1:0]         rx_thresh,
    input  logic                          rx_corr_eop,
    input  logic [N_PARAL*CORR_WIDTH-1:0] rx_corr_acc,
    input  logic [PHS_WIDTH-1:0]          rx_prn_phs,
    output logic                          tx_dwell_rst,
    output logic [PHS_WIDTH-1:0]          tx_search_phs,
    output logic [ACC_WIDTH-1:0]          tx_car_fcw,
    output logic [ACC_WIDTH-1:0]          tx_prn_fcw,
    output logic                          tx_prn_align,
    output logic                          tx_trk_rst,
    output logic                          tx_acq_suc,
    output logic                          tx_acq_fail,
    output logic [PHS_WIDTH-1:0]          tx_acq_phs,
    output logic [4:0]                    tx_acq_bin,
    output logic [CORR_WIDTH-1:0]         tx_acq_peak,
    output logic [CORR_WIDTH-1:0]         tx_acq_peak2
);

    acq_state_t             state;
    logic [PHS_WIDTH-1:0]   base;
    logic [PHS_WIDTH:0]     base_next;
    logic [4:0]             bin_idx;
    logic [CORR_WIDTH-1:0]  thresh_q;
    logic [CORR_WIDTH-1:0]  peak, peak2;
    logic [PHS_WIDTH-1:0]   peak_phs;
    logic                   start_ok, detect, trk_clear;
    logic signed [4:0]      cur_bin;
    logic signed [ACC_WIDTH-1:0] bin_ext, dopp_off, code_off;

    assign start_ok  = rx_start && (state == ST_IDLE || state == ST_DONE || state == ST_FAIL);
    assign detect    = (peak > thresh_q);
    assign trk_clear = start_ok || (state == ST_BIN_END && !detect);
    assign base_next = {1'b0, base} + (PHS_WIDTH+1)'(N_PARAL);

    // Bin register only moves on a failed bin, so the FCWs freeze on detection.
    assign cur_bin  = bin_of_idx(bin_idx);
    assign bin_ext  = {{(ACC_WIDTH-5){cur_bin[4]}}, cur_bin};
    assign dopp_off = bin_ext * $signed(DOPP_STEP);
    assign code_off = dopp_off >>> CODE_SHIFT;

    assign tx_car_fcw    = CAR_FCW_NOM - $unsigned(dopp_off);
    assign tx_prn_fcw    = PRN_FCW_NOM + $unsigned(code_off);
    assign tx_search_phs = base;
    assign tx_dwell_rst  = (state == ST_START);
    assign tx_prn_align  = (state == ST_ALIGN) && (rx_prn_phs == tx_acq_phs);

    acq_peak_tracker #(
        .N_PARAL    (N_PARAL),
        .CORR_WIDTH (CORR_WIDTH),
        .PHS_WIDTH  (PHS_WIDTH)
    ) u_peak (
        .rx_clk   (rx_clk),
        .rx_rst   (rx_rst),
        .clear    (trk_clear),
        .update   (state == ST_DWELL && rx_corr_eop),
        .base     (base),
        .acc      (rx_corr_acc),
        .peak     (peak),
        .peak2    (peak2),
        .peak_phs (peak_phs)
    );

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state        <= ST_IDLE;
            base         <= '0;
            bin_idx      <= '0;
            thresh_q     <= '0;
            tx_trk_rst   <= 1'b1;
            tx_acq_suc   <= 1'b0;
            tx_acq_fail  <= 1'b0;
            tx_acq_phs   <= '0;
            tx_acq_bin   <= '0;
            tx_acq_peak  <= '0;
            tx_acq_peak2 <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start_ok) begin
                        thresh_q    <= rx_thresh;
                        base        <= '0;
                        bin_idx     <= '0;
                        tx_trk_rst  <= 1'b1;
                        tx_acq_suc  <= 1'b0;
                        tx_acq_fail <= 1'b0;
                        state       <= ST_START;
                    end
                end
                ST_START: state <= ST_DWELL;
                ST_DWELL: if (rx_corr_eop) state <= ST_EVAL;
                ST_EVAL: begin
                    if (base_next == (PHS_WIDTH+1)'(CODE_LEN)) begin
                        base  <= '0;
                        state <= ST_BIN_END;
                    end else begin
                        base  <= base_next[PHS_WIDTH-1:0];
                        state <= ST_START;
                    end
                end
                ST_BIN_END: begin
                    if (detect) begin
                        tx_acq_phs   <= peak_phs;
                        tx_acq_bin   <= $unsigned(cur_bin);
                        tx_acq_peak  <= peak;
                        tx_acq_peak2 <= peak2;
                        tx_acq_suc   <= 1'b1;
                        state        <= ST_DETECT;
                    end else if (bin_idx == 5'(N_DOPP-1)) begin
                        tx_acq_fail <= 1'b1;
                        state       <= ST_FAIL;
                    end else begin
                        bin_idx <= bin_idx + 5'd1;
                        state   <= ST_START;
                    end
                end
                ST_DETECT: state <= ST_ALIGN;
                ST_ALIGN: begin
                    if (rx_prn_phs == tx_acq_phs) begin
                        tx_trk_rst <= 1'b0;
                        state      <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boc_acq_search.sv
// Scoreboard bench for boc_acq_search: expected dwell sequence queued per search,
// correlator responses generated from a per-scenario pattern.
module tb_boc_acq_search;

    localparam int NP = 4;
    localparam int CW = 32;
    localparam int PW = 14;
    localparam int CL = 16;
    localparam int AW = 32;
    localparam logic [31:0] CAR_NOM = 32'd1342177280;
    localparam logic [31:0] PRN_NOM = 32'd274609472;
    localparam int STEP = 214748;
    localparam int BIN_ORDER [15] = '{0, 1, -1, 2, -2, 3, -3, 4, -4, 5, -5, 6, -6, 7, -7};

    logic              rx_clk, rx_rst, rx_start, rx_corr_eop;
    logic [CW-1:0]     rx_thresh;
    logic [NP*CW-1:0]  rx_corr_acc;
    logic [PW-1:0]     rx_prn_phs;
    logic              tx_dwell_rst, tx_prn_align, tx_trk_rst, tx_acq_suc, tx_acq_fail;
    logic [PW-1:0]     tx_search_phs, tx_acq_phs;
    logic [AW-1:0]     tx_car_fcw, tx_prn_fcw;
    logic [4:0]        tx_acq_bin;
    logic [CW-1:0]     tx_acq_peak, tx_acq_peak2;

    typedef struct {
        logic [PW-1:0] phs;
        int            bin;
        logic [AW-1:0] car;
        logic [AW-1:0] prn;
    } dwell_t;

    dwell_t exp_q[$];
    int total = 0;
    int bad = 0;
    int align_cnt;
    logic [PW-1:0] align_phs;
    logic trk_at_align, trk_after_align;
    logic first_fail, first_suc, first_trk;

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    boc_acq_search #(
        .N_PARAL (NP), .CORR_WIDTH (CW), .PHS_WIDTH (PW), .CODE_LEN (CL), .ACC_WIDTH (AW)
    ) dut (
        .rx_clk (rx_clk), .rx_rst (rx_rst), .rx_start (rx_start), .rx_thresh (rx_thresh),
        .rx_corr_eop (rx_corr_eop), .rx_corr_acc (rx_corr_acc), .rx_prn_phs (rx_prn_phs),
        .tx_dwell_rst (tx_dwell_rst), .tx_search_phs (tx_search_phs),
        .tx_car_fcw (tx_car_fcw), .tx_prn_fcw (tx_prn_fcw), .tx_prn_align (tx_prn_align),
        .tx_trk_rst (tx_trk_rst), .tx_acq_suc (tx_acq_suc), .tx_acq_fail (tx_acq_fail),
        .tx_acq_phs (tx_acq_phs), .tx_acq_bin (tx_acq_bin),
        .tx_acq_peak (tx_acq_peak), .tx_acq_peak2 (tx_acq_peak2)
    );

    task automatic push_bins(input int nbins);
        dwell_t d;
        int off;
        for (int i = 0; i < nbins; i++) begin
            for (int b = 0; b < CL; b += NP) begin
                off   = BIN_ORDER[i] * STEP;
                d.phs = PW'(b);
                d.bin = BIN_ORDER[i];
                d.car = CAR_NOM - 32'(off);
                d.prn = PRN_NOM + 32'(off >>> 4);
                exp_q.push_back(d);
            end
        end
    endtask

    function automatic logic [NP*CW-1:0] lanes(input int tid, input int bin, input int base);
        logic [NP*CW-1:0] v;
        int x;
        v = '0;
        for (int k = 0; k < NP; k++) begin
            case (tid)
                1: x = (bin == 0 && base == 8 && k == 2) ? 900 : 10;
                2: x = (bin == -2 && base == 4 && k == 1) ? 800 : 100;
                4: x = ((base == 4 && (k == 1 || k == 3)) || (base == 12 && k == 0)) ? 700 : 50;
                5: x = (base == 0 && k == 3) ? 600 : 20;
                default: x = 100;
            endcase
            v[k*CW +: CW] = CW'(x);
        end
        return v;
    endfunction

    task automatic kick(input logic [CW-1:0] th);
        @(negedge rx_clk);
        rx_thresh = th;
        rx_start  = 1'b1;
    endtask

    // Plays the correlator: answers each dwell restart with an eop three cycles later.
    task automatic run_search(input int tid, input int budget, input int stop_after,
                              input int inject_at, output logic ok);
        int cnt, dwells, eop_cyc, cur_bin, cur_base, lat;
        logic pending, inj_pend, prev_align;
        dwell_t e;
        ok = 1'b0; cnt = 0; dwells = 0; eop_cyc = -1; cur_bin = 0; cur_base = 0;
        pending = 1'b0; inj_pend = 1'b0; prev_align = 1'b0;
        align_cnt = 0; align_phs = '0; trk_at_align = 1'b0; trk_after_align = 1'b1;
        for (int cyc = 0; cyc < budget && !ok; cyc++) begin
            @(negedge rx_clk);
            rx_start    = 1'b0;
            rx_corr_eop = 1'b0;
            if (inj_pend) begin
                rx_start = 1'b1;
                inj_pend = 1'b0;
            end
            if (pending) begin
                if (cnt == 0) begin
                    rx_corr_eop = 1'b1;
                    rx_corr_acc = lanes(tid, cur_bin, cur_base);
                    pending     = 1'b0;
                    eop_cyc     = cyc;
                end else cnt--;
            end
            rx_prn_phs = PW'((int'(rx_prn_phs) + 1) % CL);
            #1;
            if (prev_align) begin
                trk_after_align = tx_trk_rst;
                prev_align = 1'b0;
            end
            if (tx_prn_align) begin
                align_cnt++;
                align_phs    = rx_prn_phs;
                trk_at_align = tx_trk_rst;
                prev_align   = 1'b1;
            end
            if (tx_dwell_rst) begin
                if (dwells == 0) begin
                    first_fail = tx_acq_fail;
                    first_suc  = tx_acq_suc;
                    first_trk  = tx_trk_rst;
                end
                dwells++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_dwell: got phs=%0d car=%0d, none expected", tx_search_phs, tx_car_fcw);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_search_phs !== e.phs || tx_car_fcw !== e.car || tx_prn_fcw !== e.prn) begin
                        bad++;
                        $display("FAIL dwell_seq: got phs=%0d car=%0d prn=%0d, want phs=%0d car=%0d prn=%0d (bin %0d)",
                                 tx_search_phs, tx_car_fcw, tx_prn_fcw, e.phs, e.car, e.prn, e.bin);
                    end
                    if (eop_cyc >= 0) begin
                        lat = (e.phs == 0) ? 3 : 2;
                        total++;
                        if (cyc - eop_cyc != lat) begin
                            bad++;
                            $display("FAIL eop_latency: got %0d cycles, want %0d", cyc - eop_cyc, lat);
                        end
                    end
                    cur_bin  = e.bin;
                    cur_base = int'(e.phs);
                end
                pending = 1'b1;
                cnt     = 2;
                if (dwells == inject_at) inj_pend = 1'b1;
                if (stop_after > 0 && dwells == stop_after) ok = 1'b1;
            end
            if (tx_acq_fail === 1'b1 || (tx_acq_suc === 1'b1 && tx_trk_rst === 1'b0)) ok = 1'b1;
        end
        rx_start    = 1'b0;
        rx_corr_eop = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL search_timeout: no end after %0d cycles (tid %0d)", budget, tid);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge rx_clk);
        rx_rst = 1'b0;
        #1;
        total++;
        if ({tx_dwell_rst, tx_prn_align, tx_trk_rst, tx_acq_suc, tx_acq_fail} !== 5'b00100) begin
            bad++;
            $display("FAIL reset_flags: got %b, want 00100",
                     {tx_dwell_rst, tx_prn_align, tx_trk_rst, tx_acq_suc, tx_acq_fail});
        end
        total++;
        if (tx_car_fcw !== CAR_NOM || tx_prn_fcw !== PRN_NOM) begin
            bad++;
            $display("FAIL reset_fcw: got car=%0d prn=%0d, want %0d %0d", tx_car_fcw, tx_prn_fcw, CAR_NOM, PRN_NOM);
        end
        total++;
        if (tx_search_phs !== '0 || tx_acq_phs !== '0 || tx_acq_bin !== '0 ||
            tx_acq_peak !== '0 || tx_acq_peak2 !== '0) begin
            bad++;
            $display("FAIL reset_values: got sphs=%0d aphs=%0d bin=%0d pk=%0d pk2=%0d, want all 0",
                     tx_search_phs, tx_acq_phs, tx_acq_bin, tx_acq_peak, tx_acq_peak2);
        end
    endtask

    task automatic test_single_bin;
        logic ok;
        push_bins(1);
        kick(32'd500);
        run_search(1, 200, 0, 0, ok);
        total++;
        if (tx_acq_suc !== 1'b1 || tx_acq_fail !== 1'b0 || tx_trk_rst !== 1'b0) begin
            bad++;
            $display("FAIL t1_flags: got suc=%b fail=%b trk=%b, want 1 0 0", tx_acq_suc, tx_acq_fail, tx_trk_rst);
        end
        total++;
        if (tx_acq_phs !== 14'd10 || tx_acq_bin !== 5'd0 || tx_acq_peak !== 32'd900 || tx_acq_peak2 !== 32'd10) begin
            bad++;
            $display("FAIL t1_result: got phs=%0d bin=%0d pk=%0d pk2=%0d, want 10 0 900 10",
                     tx_acq_phs, tx_acq_bin, tx_acq_peak, tx_acq_peak2);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL t1_dwells_left: got %0d, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_bin_sweep;
        logic ok;
        push_bins(5);
        kick(32'd500);
        run_search(2, 600, 0, 0, ok);
        total++;
        if (first_suc !== 1'b0 || first_trk !== 1'b1) begin
            bad++;
            $display("FAIL t2_restart_flags: got suc=%b trk=%b, want 0 1", first_suc, first_trk);
        end
        total++;
        if (tx_acq_suc !== 1'b1 || tx_acq_bin !== 5'b11110 || tx_acq_phs !== 14'd5 ||
            tx_acq_peak !== 32'd800 || tx_acq_peak2 !== 32'd100) begin
            bad++;
            $display("FAIL t2_result: got suc=%b bin=%b phs=%0d pk=%0d pk2=%0d, want 1 11110 5 800 100",
                     tx_acq_suc, tx_acq_bin, tx_acq_phs, tx_acq_peak, tx_acq_peak2);
        end
        total++;
        if (tx_car_fcw !== 32'd1342606776 || tx_prn_fcw !== 32'd274582628) begin
            bad++;
            $display("FAIL t2_frozen_fcw: got car=%0d prn=%0d, want 1342606776 274582628", tx_car_fcw, tx_prn_fcw);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL t2_dwells_left: got %0d, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_no_detect;
        logic ok;
        push_bins(15);
        kick(32'd500);
        run_search(3, 2000, 0, 0, ok);
        total++;
        if (tx_acq_fail !== 1'b1 || tx_acq_suc !== 1'b0 || tx_trk_rst !== 1'b1) begin
            bad++;
            $display("FAIL t3_flags: got fail=%b suc=%b trk=%b, want 1 0 1", tx_acq_fail, tx_acq_suc, tx_trk_rst);
        end
        total++;
        if (align_cnt != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL t3_align_dwells: got align=%0d left=%0d, want 0 0", align_cnt, exp_q.size());
        end
        repeat (3) @(negedge rx_clk);
        #1;
        total++;
        if (tx_acq_fail !== 1'b1 || tx_dwell_rst !== 1'b0) begin
            bad++;
            $display("FAIL t3_hold: got fail=%b dwell=%b, want 1 0", tx_acq_fail, tx_dwell_rst);
        end
        exp_q.delete();
    endtask

    task automatic test_ties;
        logic ok;
        push_bins(1);
        kick(32'd500);
        run_search(4, 200, 0, 0, ok);
        total++;
        if (first_fail !== 1'b0 || first_trk !== 1'b1) begin
            bad++;
            $display("FAIL t4_restart_from_fail: got fail=%b trk=%b, want 0 1", first_fail, first_trk);
        end
        total++;
        if (tx_acq_phs !== 14'd5 || tx_acq_peak !== 32'd700 || tx_acq_peak2 !== 32'd50) begin
            bad++;
            $display("FAIL t4_tie: got phs=%0d pk=%0d pk2=%0d, want 5 700 50", tx_acq_phs, tx_acq_peak, tx_acq_peak2);
        end
        exp_q.delete();
    endtask

    task automatic test_align;
        logic ok;
        push_bins(1);
        kick(32'd500);
        run_search(5, 200, 0, 0, ok);
        total++;
        if (tx_acq_phs !== 14'd3 || tx_acq_peak !== 32'd600 || tx_acq_peak2 !== 32'd0) begin
            bad++;
            $display("FAIL t5_result: got phs=%0d pk=%0d pk2=%0d, want 3 600 0", tx_acq_phs, tx_acq_peak, tx_acq_peak2);
        end
        total++;
        if (align_cnt != 1 || align_phs !== 14'd3) begin
            bad++;
            $display("FAIL t5_align: got count=%0d phs=%0d, want 1 3", align_cnt, align_phs);
        end
        total++;
        if (trk_at_align !== 1'b1 || trk_after_align !== 1'b0) begin
            bad++;
            $display("FAIL t5_trk_rst: got at=%b after=%b, want 1 0", trk_at_align, trk_after_align);
        end
        repeat (CL + 2) begin
            @(negedge rx_clk);
            rx_prn_phs = PW'((int'(rx_prn_phs) + 1) % CL);
            #1;
            if (tx_prn_align) align_cnt++;
        end
        total++;
        if (align_cnt != 1 || tx_trk_rst !== 1'b0) begin
            bad++;
            $display("FAIL t5_done_hold: got align=%0d trk=%b, want 1 0", align_cnt, tx_trk_rst);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_and_ignore;
        logic ok;
        int stray;
        push_bins(15);
        kick(32'd500);
        run_search(3, 300, 6, 0, ok);
        exp_q.delete();
        @(negedge rx_clk);
        rx_rst = 1'b1;
        @(negedge rx_clk);
        rx_rst = 1'b0;
        #1;
        total++;
        if (tx_search_phs !== '0 || tx_car_fcw !== CAR_NOM || tx_trk_rst !== 1'b1 || tx_dwell_rst !== 1'b0) begin
            bad++;
            $display("FAIL t6_mid_reset: got phs=%0d car=%0d trk=%b dwell=%b, want 0 %0d 1 0",
                     tx_search_phs, tx_car_fcw, tx_trk_rst, tx_dwell_rst, CAR_NOM);
        end
        @(negedge rx_clk);
        rx_corr_eop = 1'b1;
        stray = 0;
        repeat (5) begin
            @(negedge rx_clk);
            rx_corr_eop = 1'b0;
            #1;
            if (tx_dwell_rst !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL t6_stale_eop: got %0d dwell restarts in idle, want 0", stray);
        end
        push_bins(1);
        kick(32'd500);
        run_search(1, 200, 0, 2, ok);
        total++;
        if (tx_acq_suc !== 1'b1 || tx_acq_phs !== 14'd10 || tx_acq_peak !== 32'd900 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL t6_ignored_start: got suc=%b phs=%0d pk=%0d left=%0d, want 1 10 900 0",
                     tx_acq_suc, tx_acq_phs, tx_acq_peak, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        rx_rst      = 1'b1;
        rx_start    = 1'b0;
        rx_thresh   = '0;
        rx_corr_eop = 1'b0;
        rx_corr_acc = '0;
        rx_prn_phs  = '0;
        test_reset();
        test_single_bin();
        test_bin_sweep();
        test_no_detect();
        test_ties();
        test_align();
        test_reset_mid_and_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
